weight_loader: RTL and testbench
================================

# weight_loader

Sequencer directly upstream of the per-unit weight demultiplexer. On a `start` pulse it reads `NUM_UNITS*WEIGHTS_PER_UNIT` consecutive 32-bit words from weight RAM, beginning at a latched base address. It presents each word on `ram_out` together with the matching `unit_sel` and a one-cycle `write` strobe, so the downstream mux can steer the word to the right neuron unit. It reports `busy` while loading and pulses `done` when finished.

## Interface
Parameters:
- `NUM_UNITS`, 4: number of neuron units loaded; legal range 1..4.
- `WEIGHTS_PER_UNIT`, 16: words per unit; legal range 1..256.
- `ADDR_W`, 10: RAM address width.
- `DATA_W`, 32: weight word width.

Ports:
- `CLOCK` in 1: single clock, all logic on its rising edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `start` in 1: load request, sampled only in IDLE.
- `base_addr` in ADDR_W: first RAM address, latched when `start` is accepted.
- `busy` out 1: high from the cycle after `start` is accepted until `done`, inclusive.
- `done` out 1: one-cycle pulse after the last `write`.
- `ram_rd` out 1: RAM read enable.
- `ram_addr` out ADDR_W: RAM read address.
- `ram_q` in DATA_W: RAM read data, valid exactly one cycle after `ram_rd`.
- `ram_out` out DATA_W: weight word to the downstream mux.
- `unit_sel` out 3: destination unit, 0..NUM_UNITS-1.
- `write` out 1: `ram_out` and `unit_sel` are valid this cycle.
- `hold` in 1: stall request. Present only when `WEIGHT_LOADER_HOLD_EN` is defined.

## Operation
- States:
  - IDLE: `start`=1 → ISSUE; latch `base_addr`; clear the unit and index counters.
  - ISSUE: `ram_rd`=1 with `ram_addr`=base + unit*WEIGHTS_PER_UNIT + idx. The index advances each cycle; at idx=WEIGHTS_PER_UNIT-1 it wraps to 0 and unit increments. After the final issue → DRAIN.
  - DRAIN: wait for the last read data to be written out → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
- Address arithmetic is modulo 2^ADDR_W; wrap past the top of RAM is silent.
- A two-stage tag pipeline (valid, unit) follows each read. When data returns, the loader registers `ram_out`<=`ram_q`, `unit_sel`<=tag unit and `write`<=1.
- `write` is 0 on every cycle that carries no word. `ram_out` and `unit_sel` hold their last values when `write`=0.
- `start` while not IDLE is ignored; the load is never restarted.
- Reset mid-load aborts immediately: all state cleared, no further `write` or `done`.

## Timing
- Reset values: `busy`=0, `done`=0, `ram_rd`=0, `ram_addr`=0, `ram_out`=0, `unit_sel`=0, `write`=0; state IDLE.
- Handshake and latency:
  - `start` is sampled at edge E0. The first `ram_rd` is at cycle E0+1.
  - The first `write` is at E0+3: one cycle of RAM latency plus one output register.
- Throughput: one word per cycle with no stalls.
- Total duration: N=NUM_UNITS*WEIGHTS_PER_UNIT issues occupy E0+1..E0+N, writes occur at E0+3..E0+N+2, and `done` is at E0+N+3.
- `busy` is high at E0+1..E0+N+3.
- Back-to-back loads: `start` is accepted again at the cycle after `done`.

## Configuration
- `WEIGHT_LOADER_HOLD_EN` defined:
  - `hold`=1 in ISSUE suppresses `ram_rd` and freezes the counters.
  - A read already in flight still completes, and its `write` still fires.
  - Dropping `hold` resumes issue on the next cycle.
  - `hold` has no effect in other states.
- Not defined: no `hold` port, and issue is never stalled.

## Structure
- Shared package `weight_loader_pkg`:
  - state enum (IDLE, ISSUE, DRAIN, DONE);
  - `UNIT_SEL_W`=3;
  - the default `ADDR_W` and `DATA_W` constants.
- One sub-module, `weight_addr_gen`: the unit/index counters plus address adder. It has inputs clear, advance and base, and outputs addr, unit and last.
- The FSM and output pipeline stay in the top module.

## Test plan
- **Basic load.** Use NUM_UNITS=4, WEIGHTS_PER_UNIT=2, base=0x010, with RAM word at addr a = 0x1000+a. Pulse `start`.
  - Expect 8 writes: (unit 0, 0x1010), (0, 0x1011), (1, 0x1012), … (3, 0x1017).
  - The first write is 3 cycles after `start`; `done` comes 11 cycles after `start`; `busy` is high for 11 cycles.
- **Start ignored when busy.** Pulse `start` again 4 cycles into a load. Expect exactly 8 writes and a single `done`.
- **Address wrap.** Use ADDR_W=4, base=0xE, WEIGHTS_PER_UNIT=2, NUM_UNITS=2. Expect `ram_addr` sequence 0xE, 0xF, 0x0, 0x1.
- **Reset mid-load.** Assert `RESET_N`=0 after the third write. All outputs must read 0 immediately, with no `done`. After release, a new `start` must produce a full, correct load.
- **Hold (macro defined).** Assert `hold` for 3 cycles after the second issue.
  - `ram_rd` is low for those 3 cycles, and the in-flight word is still written.
  - The word order is unchanged, and `done` is delayed by exactly 3 cycles.
- **Back-to-back loads.** Pulse `start` on the cycle after `done`. The second load must begin at the same relative timing as the first, with no gap errors.

Source files
------------

// File: rtl/weight_loader_pkg.sv
// weight_loader_pkg: shared types and constants for the weight loader slice.
// Holds the sequencer state encoding, the unit-select width and the default
// RAM address/data widths used by weight_loader and weight_addr_gen.
package weight_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } wl_state_e;

    localparam int UNIT_SEL_W     = 3;
    localparam int IDX_W          = 8;
    localparam int DEFAULT_ADDR_W = 10;
    localparam int DEFAULT_DATA_W = 32;

endpackage

// File: rtl/weight_addr_gen.sv
// weight_addr_gen: unit/index counters and the RAM address adder.
// The address of the current word is base + unit*WEIGHTS_PER_UNIT + idx,
// taken modulo 2^ADDR_W so that a load running past the top of RAM wraps.
module weight_addr_gen #(
    parameter int NUM_UNITS        = 4,
    parameter int WEIGHTS_PER_UNIT = 16,
    parameter int ADDR_W           = weight_loader_pkg::DEFAULT_ADDR_W
) (
    input  logic                                     CLOCK,
    input  logic                                     RESET_N,
    input  logic                                     clear,
    input  logic                                     advance,
    input  logic [ADDR_W-1:0]                        base,
    output logic [ADDR_W-1:0]                        addr,
    output logic [weight_loader_pkg::UNIT_SEL_W-1:0] unit,
    output logic                                     last
);
    import weight_loader_pkg::*;

    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(WEIGHTS_PER_UNIT - 1);
    localparam logic [UNIT_SEL_W-1:0] UNIT_LAST = UNIT_SEL_W'(NUM_UNITS - 1);

    logic [IDX_W-1:0]      idx_r;
    logic [UNIT_SEL_W-1:0] unit_r;
    logic [ADDR_W-1:0]     offset_s;

    // Walk the words of one unit, then move on to the next unit.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            idx_r  <= {IDX_W{1'b0}};
            unit_r <= {UNIT_SEL_W{1'b0}};
        end else if (clear) begin
            idx_r  <= {IDX_W{1'b0}};
            unit_r <= {UNIT_SEL_W{1'b0}};
        end else if (advance) begin
            if (idx_r == IDX_LAST) begin
                idx_r  <= {IDX_W{1'b0}};
                unit_r <= unit_r + {{(UNIT_SEL_W-1){1'b0}}, 1'b1};
            end else begin
                idx_r  <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                unit_r <= unit_r;
            end
        end else begin
            idx_r  <= idx_r;
            unit_r <= unit_r;
        end
    end

    // Word offset from the load base, truncated to the RAM address width.
    always_comb begin
        offset_s = ADDR_W'(unit_r) * ADDR_W'(WEIGHTS_PER_UNIT) + ADDR_W'(idx_r);
    end

    assign addr = base + offset_s;
    assign unit = unit_r;
    assign last = (unit_r == UNIT_LAST) && (idx_r == IDX_LAST);

endmodule

// File: rtl/weight_loader.sv
// weight_loader: streams NUM_UNITS*WEIGHTS_PER_UNIT consecutive RAM words to
// the per-unit weight demultiplexer, tagging each with its destination unit.
// Optional feature macro: WEIGHT_LOADER_HOLD_EN adds a 'hold' input that
// stalls read issue while the sequencer is in ISSUE.
module weight_loader #(
    parameter int NUM_UNITS        = 4,
    parameter int WEIGHTS_PER_UNIT = 16,
    parameter int ADDR_W           = weight_loader_pkg::DEFAULT_ADDR_W,
    parameter int DATA_W           = weight_loader_pkg::DEFAULT_DATA_W
) (
    input  logic                                     CLOCK,
    input  logic                                     RESET_N,
    input  logic                                     start,
    input  logic [ADDR_W-1:0]                        base_addr,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     ram_rd,
    output logic [ADDR_W-1:0]                        ram_addr,
    input  logic [DATA_W-1:0]                        ram_q,
    output logic [DATA_W-1:0]                        ram_out,
    output logic [weight_loader_pkg::UNIT_SEL_W-1:0] unit_sel,
`ifdef WEIGHT_LOADER_HOLD_EN
    input  logic                                     hold,
`endif
    output logic                                     write
);
    import weight_loader_pkg::*;

    wl_state_e             state_r;
    logic                  busy_r;
    logic                  done_r;
    logic [ADDR_W-1:0]     base_r;
    logic                  tag_valid_r;
    logic [UNIT_SEL_W-1:0] tag_unit_r;
    logic                  write_r;
    logic [DATA_W-1:0]     ram_out_r;
    logic [UNIT_SEL_W-1:0] unit_sel_r;

    logic                  hold_s;
    logic                  accept_s;
    logic                  issue_s;
    logic                  advance_s;
    logic                  last_s;
    logic [ADDR_W-1:0]     gen_addr_s;
    logic [UNIT_SEL_W-1:0] gen_unit_s;

`ifdef WEIGHT_LOADER_HOLD_EN
    assign hold_s = hold;
`else
    assign hold_s = 1'b0;
`endif

    // Decode accept / issue / counter-advance controls from the current state.
    always_comb begin
        accept_s  = 1'b0;
        issue_s   = 1'b0;
        advance_s = 1'b0;
        if (state_r == ST_IDLE) begin
            accept_s = start;
        end else if (state_r == ST_ISSUE) begin
            issue_s   = !hold_s;
            advance_s = !hold_s && !last_s;
        end else begin
            accept_s = 1'b0;
        end
    end

    weight_addr_gen #(
        .NUM_UNITS        (NUM_UNITS),
        .WEIGHTS_PER_UNIT (WEIGHTS_PER_UNIT),
        .ADDR_W           (ADDR_W)
    ) u_addr_gen (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .clear   (accept_s),
        .advance (advance_s),
        .base    (base_r),
        .addr    (gen_addr_s),
        .unit    (gen_unit_s),
        .last    (last_s)
    );

    // Sequencer: IDLE -> ISSUE -> DRAIN -> DONE, with registered busy/done.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            base_r  <= {ADDR_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r <= ST_ISSUE;
                        busy_r  <= 1'b1;
                        base_r  <= base_addr;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (issue_s && last_s) begin
                        state_r <= ST_DRAIN;
                    end else begin
                        state_r <= ST_ISSUE;
                    end
                end
                ST_DRAIN: begin
                    // Once the final tag has moved into the output register,
                    // the last write is on the bus and done can follow it.
                    if (!tag_valid_r) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Tag pipeline: the tag follows each read so it lines up with ram_q,
    // then the word and its unit are registered onto the output.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            tag_valid_r <= 1'b0;
            tag_unit_r  <= {UNIT_SEL_W{1'b0}};
            write_r     <= 1'b0;
            ram_out_r   <= {DATA_W{1'b0}};
            unit_sel_r  <= {UNIT_SEL_W{1'b0}};
        end else begin
            tag_valid_r <= issue_s;
            tag_unit_r  <= gen_unit_s;
            write_r     <= tag_valid_r;
            if (tag_valid_r) begin
                ram_out_r  <= ram_q;
                unit_sel_r <= tag_unit_r;
            end else begin
                ram_out_r  <= ram_out_r;
                unit_sel_r <= unit_sel_r;
            end
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign ram_rd   = issue_s;
    assign ram_addr = gen_addr_s;
    assign ram_out  = ram_out_r;
    assign unit_sel = unit_sel_r;
    assign write    = write_r;

endmodule

// File: tb/tb_weight_loader.sv
// tb_weight_loader: directed bench for weight_loader.
// Instance A: 4 units x 2 words, 10-bit addresses, base 0x010.
// Instance B: 2 units x 2 words, 4-bit addresses, base 0xE (address wrap).
// Both RAM models return word 0x1000 + address one cycle after a read.
module tb_weight_loader;

    localparam int NU_A = 4;
    localparam int W_A  = 2;
    localparam int N_A  = NU_A * W_A;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;

    logic        start_a = 1'b0;
    logic [9:0]  base_a  = 10'h010;
    logic        busy_a, done_a, ram_rd_a, write_a;
    logic [9:0]  ram_addr_a;
    logic [31:0] ram_q_a = 32'h0;
    logic [31:0] ram_out_a;
    logic [2:0]  unit_sel_a;

    logic        start_b = 1'b0;
    logic [3:0]  base_b  = 4'hE;
    logic        busy_b, done_b, ram_rd_b, write_b;
    logic [3:0]  ram_addr_b;
    logic [31:0] ram_q_b = 32'h0;
    logic [31:0] ram_out_b;
    logic [2:0]  unit_sel_b;

`ifdef WEIGHT_LOADER_HOLD_EN
    logic        hold_a = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    logic [3:0]  wrap_addr [4] = '{4'hE, 4'hF, 4'h0, 4'h1};
    logic [31:0] wrap_data [4] = '{32'h0000_100E, 32'h0000_100F, 32'h0000_1000, 32'h0000_1001};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_rd_a) ram_q_a <= 32'h0000_1000 + {22'h0, ram_addr_a};
        if (ram_rd_b) ram_q_b <= 32'h0000_1000 + {28'h0, ram_addr_b};
    end

    weight_loader #(.NUM_UNITS(NU_A), .WEIGHTS_PER_UNIT(W_A), .ADDR_W(10), .DATA_W(32)) dut_a (
        .CLOCK(clk), .RESET_N(rst_n), .start(start_a), .base_addr(base_a),
        .busy(busy_a), .done(done_a), .ram_rd(ram_rd_a), .ram_addr(ram_addr_a),
        .ram_q(ram_q_a), .ram_out(ram_out_a), .unit_sel(unit_sel_a),
`ifdef WEIGHT_LOADER_HOLD_EN
        .hold(hold_a),
`endif
        .write(write_a)
    );

    weight_loader #(.NUM_UNITS(2), .WEIGHTS_PER_UNIT(2), .ADDR_W(4), .DATA_W(32)) dut_b (
        .CLOCK(clk), .RESET_N(rst_n), .start(start_b), .base_addr(base_b),
        .busy(busy_b), .done(done_b), .ram_rd(ram_rd_b), .ram_addr(ram_addr_b),
        .ram_q(ram_q_b), .ram_out(ram_out_b), .unit_sel(unit_sel_b),
`ifdef WEIGHT_LOADER_HOLD_EN
        .hold(1'b0),
`endif
        .write(write_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Cycle c (1 = first cycle after start is sampled) carries an issue?
    // Cycles hs..hs+hl-1 are held; later issues slide by hl.
    function automatic bit is_issue(input int c, input int hs, input int hl);
        int eff;
        if (c < 1) return 1'b0;
        if (c >= hs && c < hs + hl) return 1'b0;
        eff = (c >= hs + hl) ? c - hl : c;
        return (eff <= N_A);
    endfunction

    function automatic int idx_of(input int c, input int hs, input int hl);
        return ((c >= hs + hl) ? c - hl : c) - 1;
    endfunction

    // Full load on instance A; start must already be driven high.
    task automatic check_load(input string name, input int extra_c, input int hs,
                              input int hl, input bit chain);
        int last_c;
        int wr;
        int dn;
        int ic;
        logic [9:0] ea;
        last_c = N_A + 4 + hl;
        wr = 0;
        dn = 0;
        for (int c = 1; c <= last_c; c++) begin
            @(posedge clk);
            #1;
            start_a = (c == extra_c) || (chain && c == last_c);
`ifdef WEIGHT_LOADER_HOLD_EN
            hold_a = (hl > 0) && (c >= hs) && (c < hs + hl);
`endif
            @(negedge clk);
            chk($sformatf("%s busy c%0d", name, c), 32'(busy_a), 32'(c <= N_A + 3 + hl));
            chk($sformatf("%s done c%0d", name, c), 32'(done_a), 32'(c == N_A + 3 + hl));
            chk($sformatf("%s ram_rd c%0d", name, c), 32'(ram_rd_a), 32'(is_issue(c, hs, hl)));
            if (is_issue(c, hs, hl)) begin
                ea = 10'h010 + 10'(idx_of(c, hs, hl));
                chk($sformatf("%s ram_addr c%0d", name, c), 32'(ram_addr_a), 32'(ea));
            end
            chk($sformatf("%s write c%0d", name, c), 32'(write_a), 32'(is_issue(c - 2, hs, hl)));
            if (is_issue(c - 2, hs, hl)) begin
                ic = idx_of(c - 2, hs, hl);
                chk($sformatf("%s ram_out c%0d", name, c), ram_out_a, 32'h0000_1010 + 32'(ic));
                chk($sformatf("%s unit_sel c%0d", name, c), 32'(unit_sel_a), 32'(ic / W_A));
            end
            if (write_a === 1'b1) wr++;
            if (done_a === 1'b1) dn++;
        end
        chk($sformatf("%s write count", name), 32'(wr), 32'(N_A));
        chk($sformatf("%s done count", name), 32'(dn), 32'd1);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst busy", 32'(busy_a), 32'd0);
        chk("rst done", 32'(done_a), 32'd0);
        chk("rst ram_rd", 32'(ram_rd_a), 32'd0);
        chk("rst ram_addr", 32'(ram_addr_a), 32'd0);
        chk("rst ram_out", ram_out_a, 32'd0);
        chk("rst unit_sel", 32'(unit_sel_a), 32'd0);
        chk("rst write", 32'(write_a), 32'd0);
        chk("rst b busy", 32'(busy_b), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic load, chained straight into a back-to-back second load
        @(posedge clk);
        #1;
        start_a = 1'b1;
        check_load("basic", 0, 0, 0, 1'b1);
        check_load("b2b", 0, 0, 0, 1'b0);

        // Start pulsed while busy is ignored
        @(posedge clk);
        #1;
        start_a = 1'b1;
        check_load("ignore", 4, 0, 0, 1'b0);

        // Address wrap on the 4-bit instance
        @(posedge clk);
        #1;
        start_b = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            start_b = 1'b0;
            @(negedge clk);
            chk($sformatf("wrap ram_rd c%0d", c), 32'(ram_rd_b), 32'(c <= 4));
            if (c <= 4) chk($sformatf("wrap ram_addr c%0d", c), 32'(ram_addr_b), 32'(wrap_addr[c-1]));
            chk($sformatf("wrap write c%0d", c), 32'(write_b), 32'(c >= 3 && c <= 6));
            if (c >= 3 && c <= 6) begin
                chk($sformatf("wrap ram_out c%0d", c), ram_out_b, wrap_data[c-3]);
                chk($sformatf("wrap unit_sel c%0d", c), 32'(unit_sel_b), 32'((c - 3) / 2));
            end
            chk($sformatf("wrap done c%0d", c), 32'(done_b), 32'(c == 7));
        end

        // Reset in the middle of a load, after the third write
        @(posedge clk);
        #1;
        start_a = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            #1;
            start_a = 1'b0;
            @(negedge clk);
        end
        chk("midrst third write", 32'(write_a), 32'd1);
        chk("midrst third word", ram_out_a, 32'h0000_1012);
        rst_n = 1'b0;
        #1;
        chk("midrst busy", 32'(busy_a), 32'd0);
        chk("midrst done", 32'(done_a), 32'd0);
        chk("midrst ram_rd", 32'(ram_rd_a), 32'd0);
        chk("midrst ram_addr", 32'(ram_addr_a), 32'd0);
        chk("midrst ram_out", ram_out_a, 32'd0);
        chk("midrst unit_sel", 32'(unit_sel_a), 32'd0);
        chk("midrst write", 32'(write_a), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("inrst done k%0d", k), 32'(done_a), 32'd0);
            chk($sformatf("inrst write k%0d", k), 32'(write_a), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b1;
        check_load("postrst", 0, 0, 0, 1'b0);

`ifdef WEIGHT_LOADER_HOLD_EN
        // Hold for three cycles after the second issue
        @(posedge clk);
        #1;
        start_a = 1'b1;
        check_load("hold", 0, 3, 3, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
